// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: RAM geometry, loader frame-start byte and loader FSM states.
package sap1_pkg;

  localparam int unsigned RAM_DEPTH_DEF = 16;
  localparam int unsigned WIDTH_DEF     = 8;
  localparam logic [7:0]  SYNC_DEF      = 8'hA5;

  // Shared with the RAM so both sides agree on the address width.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_CNT,
    LD_ADDR,
    LD_DATA,
    LD_CSUM,
    LD_CHECK
  } ld_state_e;

endpackage

// File: rtl/ram_loader.sv
// Program RAM front-end: passes CPU accesses through when idle, otherwise writes a
// framed, checksummed byte stream into consecutive RAM words while holding the CPU.
module ram_loader
  import sap1_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEF,
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter logic [7:0]  SYNC      = SYNC_DEF,
  localparam int unsigned ADDR_WIDTH = addr_width(RAM_DEPTH)
) (
  input  logic                  mclk,
  input  logic                  i_rst_n,
  input  logic                  mclk_en,
  input  logic                  i_valid,
  input  logic [WIDTH-1:0]      i_data,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_cpu_address,
  input  logic                  i_cpu_load_enable,
  input  logic [WIDTH-1:0]      i_cpu_load_data,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_load_enable,
  output logic [WIDTH-1:0]      o_load_data,
  output logic                  o_cpu_hold,
  output logic                  o_done,
  output logic                  o_error
);

  ld_state_e             state_q, state_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      sum_q, sum_d;
  logic                  ok_q, ok_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  accept;
  logic [WIDTH-1:0]      sum_next;

  assign o_ready  = (state_q != LD_CHECK);
  assign accept   = i_valid && o_ready;
  assign sum_next = WIDTH'(sum_q + i_data);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    ok_d    = ok_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    error_d = error_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      LD_IDLE: if (accept && i_data == SYNC) begin
        state_d = LD_CNT;
        error_d = 1'b0;
        hold_d  = 1'b1;
      end
      LD_CNT: if (accept) begin
        if (i_data == '0) begin
          state_d = LD_IDLE;
          error_d = 1'b1;
          hold_d  = 1'b0;
        end else begin
          cnt_d   = i_data;
          state_d = LD_ADDR;
        end
      end
      LD_ADDR: if (accept) begin
        addr_d  = i_data[ADDR_WIDTH-1:0];
        sum_d   = '0;
        state_d = LD_DATA;
      end
      // Write port is registered: the word accepted now is written on the next beat.
      LD_DATA: if (accept) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = i_data;
        addr_d  = (addr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : ADDR_WIDTH'(addr_q + 1'b1);
        sum_d   = sum_next;
        cnt_d   = WIDTH'(cnt_q - 1'b1);
        if (cnt_q == WIDTH'(1)) state_d = LD_CSUM;
      end
      LD_CSUM: if (accept) begin
        ok_d    = (sum_next == '0);
        state_d = LD_CHECK;
      end
      LD_CHECK: begin
        done_d  = ok_q;
        error_d = error_q | ~ok_q;
        hold_d  = 1'b0;
        state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LD_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      ok_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (mclk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      ok_q    <= ok_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    if (hold_q) begin
      o_address     = waddr_q;
      o_load_enable = we_q;
      o_load_data   = wdata_q;
    end else begin
      o_address     = i_cpu_address;
      o_load_enable = i_cpu_load_enable;
      o_load_data   = i_cpu_load_data;
    end
  end

  assign o_cpu_hold = hold_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural 16x8 RAM on the write port.
module tb_ram_loader;

  logic       mclk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       mclk_en = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = '0;
  logic       o_ready;
  logic [3:0] i_cpu_address = '0;
  logic       i_cpu_load_enable = 1'b0;
  logic [7:0] i_cpu_load_data = '0;
  logic [3:0] o_address;
  logic       o_load_enable;
  logic [7:0] o_load_data;
  logic       o_cpu_hold;
  logic       o_done;
  logic       o_error;

  ram_loader #(.RAM_DEPTH(16), .WIDTH(8), .SYNC(8'hA5)) dut (
    .mclk(mclk), .i_rst_n(i_rst_n), .mclk_en(mclk_en),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .i_cpu_address(i_cpu_address), .i_cpu_load_enable(i_cpu_load_enable),
    .i_cpu_load_data(i_cpu_load_data),
    .o_address(o_address), .o_load_enable(o_load_enable), .o_load_data(o_load_data),
    .o_cpu_hold(o_cpu_hold), .o_done(o_done), .o_error(o_error)
  );

  always #5 mclk = ~mclk;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned d0;
  bit          gate = 1'b0;
  int unsigned ph = 0;
  bit          ram_clr = 1'b1;
  logic [7:0]  ram [16];

  always @(posedge mclk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else if (mclk_en && o_load_enable) begin
      ram[o_address] <= o_load_data;
    end
  end

  always @(o_done) if (o_done === 1'b1) done_cnt++;

  task automatic set_en();
    if (gate) begin
      mclk_en = (ph % 3 == 0);
      ph++;
    end else begin
      mclk_en = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      set_en();
      @(negedge mclk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit acc;
    bit ok = 1'b0;
    i_valid = 1'b1;
    i_data  = b;
    for (int n = 0; n < 40; n++) begin
      set_en();
      acc = mclk_en && o_ready;
      @(negedge mclk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    i_valid = 1'b0;
    total_cnt++;
    if (!ok) $display("FAIL send_timeout: byte %h not accepted, required accept within 40 cycles", b);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    #1;
    total_cnt++; if (o_cpu_hold !== 1'b0) $display("FAIL rst_hold: got %b want 0", o_cpu_hold); else pass_cnt++;
    total_cnt++; if (o_done !== 1'b0) $display("FAIL rst_done: got %b want 0", o_done); else pass_cnt++;
    total_cnt++; if (o_error !== 1'b0) $display("FAIL rst_error: got %b want 0", o_error); else pass_cnt++;
    total_cnt++; if (o_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", o_ready); else pass_cnt++;
    total_cnt++; if (o_load_enable !== 1'b0) $display("FAIL rst_we: got %b want 0", o_load_enable); else pass_cnt++;
    @(negedge mclk);
    ram_clr = 1'b0;
    i_rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_load();
    d0 = done_cnt;
    send(8'hA5);
    total_cnt++; if (o_cpu_hold !== 1'b1) $display("FAIL load_hold_after_sync: got %b want 1", o_cpu_hold); else pass_cnt++;
    send(8'h03); send(8'h04); send(8'h11);
    total_cnt++; if ({o_load_enable, o_address, o_load_data} !== {1'b1, 4'h4, 8'h11})
      $display("FAIL load_first_write: got we=%b a=%h d=%h want we=1 a=4 d=11", o_load_enable, o_address, o_load_data); else pass_cnt++;
    send(8'h22); send(8'h33);
    total_cnt++; if ({o_load_enable, o_address, o_load_data} !== {1'b1, 4'h6, 8'h33})
      $display("FAIL load_last_write: got we=%b a=%h d=%h want we=1 a=6 d=33", o_load_enable, o_address, o_load_data); else pass_cnt++;
    send(8'h9A);
    total_cnt++; if ({o_ready, o_cpu_hold, o_done, o_load_enable} !== 4'b0100)
      $display("FAIL load_check_state: got ready/hold/done/we=%b want 0100", {o_ready, o_cpu_hold, o_done, o_load_enable}); else pass_cnt++;
    idle(1);
    total_cnt++; if ({o_done, o_cpu_hold, o_error, o_ready} !== 4'b1001)
      $display("FAIL load_done: got done/hold/err/ready=%b want 1001", {o_done, o_cpu_hold, o_error, o_ready}); else pass_cnt++;
    mclk_en = 1'b0;
    repeat (2) @(negedge mclk);
    total_cnt++; if (o_done !== 1'b1) $display("FAIL load_done_held_en0: got %b want 1", o_done); else pass_cnt++;
    idle(1);
    total_cnt++; if (o_done !== 1'b0) $display("FAIL load_done_pulse_end: got %b want 0", o_done); else pass_cnt++;
    total_cnt++; if ({ram[4], ram[5], ram[6]} !== 24'h112233)
      $display("FAIL load_ram: got %h%h%h want 112233", ram[4], ram[5], ram[6]); else pass_cnt++;
    total_cnt++; if (done_cnt !== d0 + 1) $display("FAIL load_done_count: got %0d want %0d", done_cnt, d0 + 1); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [7:0] f [6] = '{8'hA5, 8'h02, 8'h0F, 8'h01, 8'h02, 8'hFD};
    d0 = done_cnt;
    foreach (f[i]) send(f[i]);
    idle(2);
    total_cnt++; if ({ram[15], ram[0]} !== 16'h0102) $display("FAIL wrap_ram: got %h,%h want 01,02", ram[15], ram[0]); else pass_cnt++;
    total_cnt++; if (done_cnt !== d0 + 1) $display("FAIL wrap_done: got %0d want %0d", done_cnt, d0 + 1); else pass_cnt++;
    total_cnt++; if (o_error !== 1'b0) $display("FAIL wrap_error: got %b want 0", o_error); else pass_cnt++;
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f [5] = '{8'hA5, 8'h01, 8'h00, 8'h55, 8'h00};
    d0 = done_cnt;
    foreach (f[i]) send(f[i]);
    idle(2);
    total_cnt++; if (ram[0] !== 8'h55) $display("FAIL bad_ram: got %h want 55", ram[0]); else pass_cnt++;
    total_cnt++; if (o_error !== 1'b1) $display("FAIL bad_error: got %b want 1", o_error); else pass_cnt++;
    total_cnt++; if (done_cnt !== d0) $display("FAIL bad_no_done: got %0d want %0d", done_cnt, d0); else pass_cnt++;
    total_cnt++; if (o_cpu_hold !== 1'b0) $display("FAIL bad_hold: got %b want 0", o_cpu_hold); else pass_cnt++;
    send(8'hA5);
    total_cnt++; if (o_error !== 1'b0) $display("FAIL bad_sync_clears: got %b want 0", o_error); else pass_cnt++;
    send(8'h00);
    total_cnt++; if ({o_error, o_cpu_hold} !== 2'b10) $display("FAIL bad_abort: got err/hold=%b want 10", {o_error, o_cpu_hold}); else pass_cnt++;
  endtask

  task automatic test_count_zero();
    send(8'h00); send(8'hFF);
    total_cnt++; if ({o_cpu_hold, o_error} !== 2'b01) $display("FAIL cz_junk: got hold/err=%b want 01", {o_cpu_hold, o_error}); else pass_cnt++;
    send(8'hA5);
    total_cnt++; if ({o_cpu_hold, o_error} !== 2'b10) $display("FAIL cz_sync: got hold/err=%b want 10", {o_cpu_hold, o_error}); else pass_cnt++;
    send(8'h00);
    total_cnt++; if ({o_cpu_hold, o_error, o_ready, o_load_enable} !== 4'b0110)
      $display("FAIL cz_abort: got hold/err/ready/we=%b want 0110", {o_cpu_hold, o_error, o_ready, o_load_enable}); else pass_cnt++;
    idle(2);
    total_cnt++; if (ram[0] !== 8'h55) $display("FAIL cz_no_write: got %h want 55", ram[0]); else pass_cnt++;
  endtask

  task automatic test_passthrough();
    logic [7:0] f [6] = '{8'h03, 8'h04, 8'h11, 8'h22, 8'h33, 8'h9A};
    logic [7:0] v [4] = '{8'h7E, 8'h00, 8'h00, 8'h00};
    bit dropped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_cpu_address = 4'(3 + i);
      i_cpu_load_data = v[i];
      i_cpu_load_enable = 1'b1;
      #1;
      if (i == 0) begin
        total_cnt++; if ({o_load_enable, o_address, o_load_data} !== {1'b1, 4'h3, 8'h7E})
          $display("FAIL pt_mux: got we=%b a=%h d=%h want we=1 a=3 d=7e", o_load_enable, o_address, o_load_data); else pass_cnt++;
      end
      idle(1);
    end
    i_cpu_load_enable = 1'b0;
    total_cnt++; if ({ram[3], ram[4]} !== 16'h7E00) $display("FAIL pt_ram: got %h,%h want 7e,00", ram[3], ram[4]); else pass_cnt++;
    d0 = done_cnt;
    gate = 1'b1;
    ph = 0;
    send(8'hA5);
    i_cpu_address = 4'h3;
    i_cpu_load_data = 8'h00;
    i_cpu_load_enable = 1'b1;
    #1;
    total_cnt++; if (o_load_enable !== 1'b0) $display("FAIL pt_hold_blocks: got %b want 0", o_load_enable); else pass_cnt++;
    foreach (f[i]) send(f[i]);
    i_cpu_load_enable = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (!o_cpu_hold) begin
        dropped = 1'b1;
        break;
      end
      idle(1);
    end
    total_cnt++; if (!dropped) $display("FAIL pt_hold_drop_timeout: hold=%b want 0 within 30 cycles", o_cpu_hold); else pass_cnt++;
    idle(6);
    gate = 1'b0;
    idle(1);
    total_cnt++; if ({ram[3], ram[4], ram[5], ram[6]} !== 32'h7E112233)
      $display("FAIL pt_gated_ram: got %h %h %h %h want 7e 11 22 33", ram[3], ram[4], ram[5], ram[6]); else pass_cnt++;
    total_cnt++; if ({done_cnt == d0 + 1, o_error} !== 2'b10)
      $display("FAIL pt_gated_done: got pulses=%0d err=%b want %0d,0", done_cnt - d0, o_error, 1); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] f1 [5] = '{8'hA5, 8'h03, 8'h08, 8'hAA, 8'hBB};
    logic [7:0] f2 [5] = '{8'hA5, 8'h01, 8'h0C, 8'hCC, 8'h34};
    foreach (f1[i]) send(f1[i]);
    idle(1);
    i_rst_n = 1'b0;
    #1;
    total_cnt++; if ({o_cpu_hold, o_done, o_error, o_ready, o_load_enable} !== 5'b00010)
      $display("FAIL mid_rst_outputs: got hold/done/err/ready/we=%b want 00010", {o_cpu_hold, o_done, o_error, o_ready, o_load_enable}); else pass_cnt++;
    @(negedge mclk);
    i_rst_n = 1'b1;
    d0 = done_cnt;
    foreach (f2[i]) send(f2[i]);
    idle(3);
    total_cnt++; if ({ram[8], ram[9], ram[10], ram[12]} !== 32'hAABB00CC)
      $display("FAIL mid_ram: got %h %h %h %h want aa bb 00 cc", ram[8], ram[9], ram[10], ram[12]); else pass_cnt++;
    total_cnt++; if ({done_cnt == d0 + 1, o_error} !== 2'b10)
      $display("FAIL mid_fresh_done: got pulses=%0d err=%b want 1,0", done_cnt - d0, o_error); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_bad_checksum();
    test_count_zero();
    test_passthrough();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
